uart_word_assembler: RTL

Collects consecutive bytes from the UART receive path into one 32-bit command word for the synthesizer serial programmers (FS1..FS4 signal generators). It sits between `UartRX8N1` (byte + done strobe) and the FS serial-word generator, and replaces the ad-hoc byte-to-word register. A partial word is discarded after an inter-byte timeout, so a lost byte cannot permanently misalign the stream. The completed word is presented with a valid/ready handshake.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rise_detect.sv | 25 ++
 rtl/uart_word_assembler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: state encoding, byte width and default timeout.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } uart_state_e;

    localparam int unsigned UART_BYTE_W            = 8;
    // 1 ms of inter-byte silence at 12 MHz
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 12_000;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector. The delayed copy resets to RESET_VAL so a level
// that is already high when reset releases is not reported as an edge.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_reset,
    input  logic level,
    output logic rise
);

    logic level_d;

    // Delay the level by one clock for edge comparison
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            level_d <= RESET_VAL;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/uart_word_assembler.sv
// Packs consecutive UART bytes (first byte in the low lane) into one command word,
// drops a partial word after an inter-byte timeout, and offers the finished word on a
// valid/ready handshake. All outputs come straight from flops.
module uart_word_assembler
    import uart_pkg::*;
#(
    parameter int unsigned BYTES          = 4,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                         clkIN,
    input  logic                         nResetIN,
    input  logic [UART_BYTE_W-1:0]       dataIN,
    input  logic                         storeIN,
    input  logic                         readyIN,
    output logic [UART_BYTE_W*BYTES-1:0] wordOUT,
    output logic                         validOUT,
    output logic [2:0]                   countOUT,
    output logic                         timeoutOUT,
    output logic                         overrunOUT
);

    localparam int unsigned WORD_W  = UART_BYTE_W * BYTES;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);

    // Timer value seen in the last idle cycle before the discard takes effect
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 2);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]         LAST_COUNT = 3'(BYTES - 1);

    uart_state_e        state;
    logic [2:0]         count;
    logic [TIMER_W-1:0] timer;
    logic [WORD_W-1:0]  word;
    logic [WORD_W-1:0]  word_ins;
    logic               valid;
    logic               timeout;
    logic               overrun;
    logic               store_rise;

    rise_detect #(
        .RESET_VAL (1'b1)
    ) u_store_rise (
        .clk     (clkIN),
        .n_reset (nResetIN),
        .level   (storeIN),
        .rise    (store_rise)
    );

    // Current word with the incoming byte placed in lane [count]
    always_comb begin
        word_ins = word;
        for (int k = 0; k < int'(BYTES); k++) begin
            if (count == 3'(k)) begin
                word_ins[k*UART_BYTE_W +: UART_BYTE_W] = dataIN;
            end
        end
    end

    // Assembly FSM with registered word, count, handshake and event pulses
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state   <= IDLE;
            count   <= '0;
            timer   <= '0;
            word    <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            overrun <= 1'b0;
        end else begin
            timeout <= 1'b0;
            overrun <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (store_rise) begin
                        word  <= word_ins;
                        count <= 3'd1;
                        timer <= '0;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    // A byte arriving on the expiry cycle wins over the timeout
                    if (store_rise) begin
                        word  <= word_ins;
                        timer <= '0;
                        if (count == LAST_COUNT) begin
                            count <= '0;
                            valid <= 1'b1;
                            state <= HOLD;
                        end else begin
                            count <= count + 3'd1;
                        end
                    end else if (timer == TIMER_LAST) begin
                        // Partial word abandoned; word lanes are left as they are
                        count   <= '0;
                        timer   <= '0;
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else if (timer != TIMER_MAX) begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                HOLD: begin
                    if (valid && readyIN) begin
                        valid <= 1'b0;
                        if (store_rise) begin
                            // count is 0 here, so word_ins fills lane 0 of the next word
                            word  <= word_ins;
                            count <= 3'd1;
                            timer <= '0;
                            state <= COLLECT;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (store_rise) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign wordOUT    = word;
    assign validOUT   = valid;
    assign countOUT   = count;
    assign timeoutOUT = timeout;
    assign overrunOUT = overrun;

endmodule
